// File: rtl/rcv_ctrl_if.sv
// rcv_ctrl_if: bundles the serial-receiver control and host buffer signals.
//   Parameter: NUM_DATA_BITS - width of packet_data / rx_data.
//   slave  modport: the receive controller (rcv_ctrl).
//   master modport: the surrounding receiver datapath / host that drives
//                   the controller inputs and consumes its outputs.
interface rcv_ctrl_if #(
    parameter int NUM_DATA_BITS = 8
);
    logic                     start_bit_detected;
    logic                     packet_done;
    logic                     stop_bit;
    logic [NUM_DATA_BITS-1:0] packet_data;
    logic                     data_read;
    logic                     enable_timer;
    logic                     sbc_clear;
    logic                     sbc_enable;
    logic [NUM_DATA_BITS-1:0] rx_data;
    logic                     data_ready;
    logic                     overrun_error;
    logic                     framing_error;
    logic [7:0]               err_count;

    modport slave (
        input  start_bit_detected, packet_done, stop_bit, packet_data, data_read,
        output enable_timer, sbc_clear, sbc_enable, rx_data, data_ready,
               overrun_error, framing_error, err_count
    );

    modport master (
        output start_bit_detected, packet_done, stop_bit, packet_data, data_read,
        input  enable_timer, sbc_clear, sbc_enable, rx_data, data_ready,
               overrun_error, framing_error, err_count
    );
endinterface

// File: rtl/rcv_ctrl.sv
// rcv_ctrl: receive control FSM and output data buffer for the serial receiver.
//   Sequences a frame (start, data bits, stop-bit check, load) and holds the
//   received word for the host with data_ready / overrun / framing status.
// Ports:
//   clk   - system clock, rising edge
//   n_rst - asynchronous active-low reset
//   bus   - rcv_ctrl_if.slave: start_bit_detected, packet_done, stop_bit,
//           packet_data, data_read in; enable_timer, sbc_clear, sbc_enable,
//           rx_data, data_ready, overrun_error, framing_error, err_count out.
// Optional feature macro: RCV_ERR_CNT_EN
//   defined   - err_count is an 8-bit saturating error-event counter
//   undefined - err_count is tied to 0
module rcv_ctrl #(
    parameter int NUM_DATA_BITS = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    rcv_ctrl_if.slave   bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] RECEIVE  = 3'd2;
    localparam logic [2:0] STOP_CHK = 3'd3;
    localparam logic [2:0] CHECK    = 3'd4;
    localparam logic [2:0] LOAD     = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [NUM_DATA_BITS-1:0] rx_data_q;
    logic                     data_ready_q;
    logic                     overrun_q;
    logic                     framing_q;
    logic                     overrun_set;

    // A load overwrites an unread word unless the host reads in the same cycle.
    assign overrun_set = (state_q == LOAD) && data_ready_q && !bus.data_read;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start_bit_detected) state_d = START;
            START:    state_d = RECEIVE;
            RECEIVE:  if (bus.packet_done) state_d = STOP_CHK;
            STOP_CHK: state_d = CHECK;
            CHECK:    state_d = framing_q ? IDLE : LOAD;
            LOAD:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            if (state_q == START)
                framing_q <= 1'b0;
            else if (state_q == STOP_CHK)
                framing_q <= ~bus.stop_bit;

            // Load takes priority over a simultaneous host read.
            if (state_q == LOAD) begin
                rx_data_q    <= bus.packet_data;
                data_ready_q <= 1'b1;
                overrun_q    <= overrun_set;
            end else if (bus.data_read) begin
                data_ready_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

`ifdef RCV_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_evt;

    assign err_evt = ((state_q == CHECK) && framing_q) || overrun_set;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            err_cnt_q <= '0;
        else if (err_evt && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = '0;
`endif

    // Moore strobes decoded from the state register only.
    assign bus.enable_timer  = (state_q == RECEIVE);
    assign bus.sbc_clear     = (state_q == START);
    assign bus.sbc_enable    = (state_q == STOP_CHK);
    assign bus.rx_data       = rx_data_q;
    assign bus.data_ready    = data_ready_q;
    assign bus.overrun_error = overrun_q;
    assign bus.framing_error = framing_q;
endmodule

// File: tb/tb_rcv_ctrl.sv
module tb_rcv_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    rcv_ctrl_if #(.NUM_DATA_BITS(W)) bus ();
    rcv_ctrl #(.NUM_DATA_BITS(W)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    // Expected output values for the current cycle (transaction-level model).
    logic         e_en, e_clr, e_sbe, e_rdy, e_ovr, e_fe;
    logic [W-1:0] e_rx;
    int           e_cnt;
    int           checks = 0;
    int           errors = 0;
    bit           chk_en = 0;
    int           n_en, n_clr, n_sbe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic err_evt();
`ifdef RCV_ERR_CNT_EN
        if (e_cnt < 255) e_cnt++;
`endif
    endtask

    task automatic model_reset();
        e_en = 0; e_clr = 0; e_sbe = 0; e_rdy = 0; e_ovr = 0; e_fe = 0;
        e_rx = '0; e_cnt = 0;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("enable_timer",  {31'd0, bus.enable_timer},  {31'd0, e_en});
            chk("sbc_clear",     {31'd0, bus.sbc_clear},     {31'd0, e_clr});
            chk("sbc_enable",    {31'd0, bus.sbc_enable},    {31'd0, e_sbe});
            chk("data_ready",    {31'd0, bus.data_ready},    {31'd0, e_rdy});
            chk("overrun_error", {31'd0, bus.overrun_error}, {31'd0, e_ovr});
            chk("framing_error", {31'd0, bus.framing_error}, {31'd0, e_fe});
            chk("rx_data",       {24'd0, bus.rx_data},       {24'd0, e_rx});
            chk("err_count",     {24'd0, bus.err_count},     e_cnt);
            if (bus.enable_timer === 1'b1) n_en++;
            if (bus.sbc_clear === 1'b1)    n_clr++;
            if (bus.sbc_enable === 1'b1)   n_sbe++;
        end
    end

    // One frame starting from IDLE: n RECEIVE cycles, packet_done in the last.
    task automatic frame(input int n, input bit stop, input logic [W-1:0] d,
                         input bit rd_load, input bit spur);
        logic old_rdy;
        n_en = 0; n_clr = 0; n_sbe = 0;
        bus.start_bit_detected = 1; step(); bus.start_bit_detected = 0;
        e_clr = 1;                                   // START
        step(); e_clr = 0; e_en = 1; e_fe = 0;       // RECEIVE
        for (int j = 1; j <= n; j++) begin
            bus.packet_done        = (j == n);
            bus.start_bit_detected = spur && (j == 1);
            step();
            bus.packet_done = 0; bus.start_bit_detected = 0;
            if (j == n) begin e_en = 0; e_sbe = 1; end // STOP_CHK
        end
        bus.stop_bit = stop; bus.packet_data = ~d;
        step();                                      // CHECK
        bus.stop_bit = ~stop;
        e_sbe = 0; e_fe = ~stop;
        if (!stop) begin
            step(); err_evt();                       // back to IDLE
        end else begin
            step();                                  // LOAD
            bus.packet_data = d; bus.data_read = rd_load;
            step();                                  // IDLE, buffer updated
            bus.data_read = 0; bus.packet_data = ~d;
            old_rdy = e_rdy;
            e_ovr = old_rdy & ~rd_load;
            if (e_ovr) err_evt();
            e_rdy = 1; e_rx = d;
        end
        bus.stop_bit = 0;
    endtask

    task automatic read_pulse();
        bus.data_read = 1; step(); bus.data_read = 0;
        e_rdy = 0; e_ovr = 0;
    endtask

    initial begin
        bus.start_bit_detected = 0; bus.packet_done = 0; bus.stop_bit = 0;
        bus.packet_data = '0; bus.data_read = 0;
        model_reset();
        #1 chk_en = 1;
        repeat (2) step();
        n_rst = 1;
        step();

        // Good frame, then reset mid-RECEIVE abandons the next frame.
        frame(10, 1, 8'hA5, 0, 0);
        chk("pre_reset_rx", {24'd0, bus.rx_data}, 32'hA5);
        bus.start_bit_detected = 1; step(); bus.start_bit_detected = 0;
        e_clr = 1;
        step(); e_clr = 0; e_en = 1; e_fe = 0;
        step();
        n_rst = 0; #1;
        model_reset();
        chk("rst_enable_timer", {31'd0, bus.enable_timer}, 32'd0);
        chk("rst_rx_data",      {24'd0, bus.rx_data},      32'd0);
        chk("rst_data_ready",   {31'd0, bus.data_ready},   32'd0);
        step(); step();
        n_rst = 1;
        bus.packet_done = 1; step(); bus.packet_done = 0;  // ignored in IDLE
        step(); step();

        // Good frame A5: pin pulse counts and buffer.
        frame(10, 1, 8'hA5, 0, 0);
        chk("good_en_cycles",  n_en,  32'd10);
        chk("good_clr_pulses", n_clr, 32'd1);
        chk("good_sbe_pulses", n_sbe, 32'd1);
        chk("good_rx",   {24'd0, bus.rx_data},       32'hA5);
        chk("good_rdy",  {31'd0, bus.data_ready},    32'd1);
        chk("good_fe",   {31'd0, bus.framing_error}, 32'd0);

        // Framing error: buffer untouched.
        frame(10, 0, 8'h3C, 0, 0);
        chk("fe_flag", {31'd0, bus.framing_error}, 32'd1);
        chk("fe_rx",   {24'd0, bus.rx_data},       32'hA5);
        chk("fe_rdy",  {31'd0, bus.data_ready},    32'd1);
`ifdef RCV_ERR_CNT_EN
        chk("fe_cnt",  {24'd0, bus.err_count},     32'd1);
`endif
        step(); step();
        chk("fe_holds", {31'd0, bus.framing_error}, 32'd1);
        read_pulse();

        // Overrun: two frames, no read.
        frame(3, 1, 8'h11, 0, 0);
        frame(4, 1, 8'h22, 0, 0);
        chk("ovr_rx",   {24'd0, bus.rx_data},       32'h22);
        chk("ovr_flag", {31'd0, bus.overrun_error}, 32'd1);
        read_pulse();
        chk("ovr_clr_rdy", {31'd0, bus.data_ready},    32'd0);
        chk("ovr_clr_ovr", {31'd0, bus.overrun_error}, 32'd0);
        chk("ovr_keep_rx", {24'd0, bus.rx_data},       32'h22);

        // Read coinciding with LOAD of the second frame.
        frame(2, 1, 8'h33, 0, 0);
        frame(2, 1, 8'h44, 1, 0);
        chk("sim_rdy", {31'd0, bus.data_ready},    32'd1);
        chk("sim_ovr", {31'd0, bus.overrun_error}, 32'd0);
        chk("sim_rx",  {24'd0, bus.rx_data},       32'h44);

        // Spurious strobes.
        bus.packet_done = 1; step(); step(); bus.packet_done = 0; step();
        frame(5, 1, 8'h5A, 1, 1);
        chk("spur_clr_pulses", n_clr, 32'd1);
        chk("spur_en_cycles",  n_en,  32'd5);
        chk("spur_rx", {24'd0, bus.rx_data}, 32'h5A);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) frame(1, 0, 8'h00, 0, 0);
`ifdef RCV_ERR_CNT_EN
        chk("sat_cnt", {24'd0, bus.err_count}, 32'd255);
`else
        chk("nocnt", {24'd0, bus.err_count}, 32'd0);
`endif
        chk("sat_rx", {24'd0, bus.rx_data}, 32'h5A);
        step();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rcv_ctrl.md
Name: rcv_ctrl

Overview:
- Receive control unit and output data buffer for the serial receiver.
- Sequences one frame: start detect, data bits, stop-bit check, then load into the buffer.
- Drives the bit-period timer built from flex_counter and consumes its rollover as packet_done.
- Holds the received byte for the host with data_ready/overrun handshake, plus framing status.

Parameters:
NUM_DATA_BITS, 8, width of packet_data and rx_data

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
start_bit_detected  input  1  one-cycle pulse from start-bit detector
packet_done  input  1  timer rollover; final (stop) bit sampled this cycle
stop_bit  input  1  sampled stop bit from shift register, valid when packet_done seen
packet_data  input  NUM_DATA_BITS  parallel data from shift register
data_read  input  1  host pulse: buffer consumed
enable_timer  output  1  run bit timer / shift register
sbc_clear  output  1  clear stop-bit/timer counters for new frame
sbc_enable  output  1  stop-bit check strobe
rx_data  output  NUM_DATA_BITS  buffered received word
data_ready  output  1  rx_data holds unread word
overrun_error  output  1  word overwritten before read
framing_error  output  1  last frame had stop_bit == 0
err_count  output  8  error event count (see Optional Feature)

Behaviour:
- Reset (async, n_rst low): state IDLE; all outputs 0, rx_data = 0. Reset mid-frame abandons the frame; no partial load.
- FSM states: IDLE, START, RECEIVE, STOP_CHK, CHECK, LOAD. Moore decode of enable_timer, sbc_clear, sbc_enable from the state register.
- IDLE: strobes 0. start_bit_detected=1 -> START.
- START: sbc_clear=1 for exactly one cycle; framing_error <= 0 -> RECEIVE.
- RECEIVE: enable_timer=1. Stay until packet_done=1 -> STOP_CHK. enable_timer drops the cycle after packet_done is seen.
- STOP_CHK: sbc_enable=1 for one cycle; framing_error <= ~stop_bit (stop_bit captured in this cycle) -> CHECK.
- CHECK: framing_error=1 -> IDLE, no load, data_ready unchanged. Otherwise -> LOAD.
- LOAD: rx_data <= packet_data; data_ready <= 1.
  - overrun_error <= 1 if data_ready was 1 and data_read=0 this cycle. -> IDLE.
- Frame latency: start_bit_detected to data_ready high = 4 cycles plus the RECEIVE duration. Sequence is start pulse, START, RECEIVE..., STOP_CHK, CHECK, LOAD; data_ready is visible the cycle after LOAD.
- start_bit_detected outside IDLE: ignored. packet_done outside RECEIVE: ignored.
- data_read=1 (not in LOAD): data_ready <= 0 and overrun_error <= 0 next cycle. No effect on rx_data.
- data_read=1 in the LOAD cycle: load wins, so data_ready stays 1 and overrun_error <= 0.
- framing_error holds until the next START or reset.
- All outputs registered or decoded from state only; no combinational input-to-output paths.

Optional Feature:
- Macro: RCV_ERR_CNT_EN.
- Defined: err_count is an 8-bit saturating counter; reset 0.
  - +1 on each CHECK cycle with framing_error=1.
  - +1 on each LOAD cycle that sets overrun_error.
  - Holds at 255. Never cleared except by reset.
- Undefined: err_count tied to 0; no counter logic synthesised. All other behaviour is identical.

Test Plan:
- Reset mid-RECEIVE: n_rst low with enable_timer=1 -> all outputs 0 immediately. After release, IDLE with no load.
- Good frame: start pulse, packet_done after 10 cycles, stop_bit=1, packet_data=8'hA5 -> expected response:
  - sbc_clear one pulse;
  - enable_timer high 10 cycles;
  - sbc_enable one pulse;
  - rx_data=8'hA5, data_ready=1, framing_error=0.
- Framing error: same frame with stop_bit=0, packet_data=8'h3C -> framing_error=1; data_ready and rx_data unchanged. err_count=1 when RCV_ERR_CNT_EN is defined.
- Overrun: two good frames (8'h11 then 8'h22) with no data_read -> rx_data=8'h22, data_ready=1, overrun_error=1. Then data_read pulse -> both 0 next cycle.
- Simultaneous: data_read=1 during the LOAD cycle of the second frame -> data_ready=1, overrun_error=0, rx_data=second word.
- Spurious strobes: start_bit_detected during RECEIVE and packet_done during IDLE -> no state change, no extra pulses. With RCV_ERR_CNT_EN, 260 framing errors -> err_count=255.
